// File: rtl/demux_1to4_buf.sv
// 1-to-4 buffered demultiplexer: routes d to one of four per-lane FIFOs chosen by {I1,I0}.
// Optional macro DEMUX_TRISTATE_OUT_EN drives an empty lane's output to high-Z instead of 0.
module demux_1to4_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             I0,
    input  logic             I1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [3:0]       q_valid,
    input  logic [3:0]       q_ready,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]       w_sel;
    logic [3:0]       w_full;
    logic [3:0]       w_push;
    logic [WIDTH-1:0] w_q [4];
    logic             r_overflow;

    assign w_sel    = {I1, I0};
    assign in_ready = ~w_full[w_sel];
    assign overflow = r_overflow;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_lane
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_wr_ptr;
        logic [AW-1:0]    r_rd_ptr;
        logic [CW-1:0]    r_count;
        logic             w_pop;

        assign w_full[n]  = (r_count == FULL);
        assign w_push[n]  = in_valid && !w_full[n] && (w_sel == 2'(n));
        assign q_valid[n] = (r_count != '0);
        assign w_pop      = q_valid[n] && q_ready[n];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[n]) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push[n], w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: ;
                endcase
            end
        end

        // NOTE: storage is left unreset; outputs are gated by r_count, so stale words are never visible.
        always_ff @(posedge clk) begin
            if (w_push[n]) r_mem[r_wr_ptr] <= d;
        end

`ifdef DEMUX_TRISTATE_OUT_EN
        assign w_q[n] = q_valid[n] ? r_mem[r_rd_ptr] : {WIDTH{1'bz}};
`else
        assign w_q[n] = q_valid[n] ? r_mem[r_rd_ptr] : '0;
`endif
    end

    assign q1 = w_q[0];
    assign q2 = w_q[1];
    assign q3 = w_q[2];
    assign q4 = w_q[3];
endmodule

// File: tb/tb_demux_1to4_buf.sv
// Self-checking bench for demux_1to4_buf: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a queue-based lane model.
module tb_demux_1to4_buf;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] q1, q2, q3, q4;
    logic [3:0]       q_valid;
    logic [3:0]       q_ready;
    logic             overflow;

    int n_checks = 0;
    int n_err    = 0;

    demux_1to4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .I0       (sel[0]),
        .I1       (sel[1]),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q1       (q1),
        .q2       (q2),
        .q3       (q3),
        .q4       (q4),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] qr;
        logic       exp_ready;
        logic [7:0] e1, e2, e3, e4;
        logic [3:0] eqv;
        logic       eov;
    } vec_t;

    vec_t vecs [14];

    // Lane model: one queue per lane plus the sticky overflow flag.
    logic [7:0] mq [4][$];
    logic       m_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input logic [7:0] e4,
                              input logic [3:0] eqv, input logic eov);
        check($sformatf("%s q1", tag), 32'(q1), 32'(e1));
        check($sformatf("%s q2", tag), 32'(q2), 32'(e2));
        check($sformatf("%s q3", tag), 32'(q3), 32'(e3));
        check($sformatf("%s q4", tag), 32'(q4), 32'(e4));
        check($sformatf("%s q_valid", tag), 32'(q_valid), 32'(eqv));
        check($sformatf("%s overflow", tag), 32'(overflow), 32'(eov));
    endtask

    task automatic apply(input logic iv, input logic [1:0] s, input logic [7:0] dd, input logic [3:0] qr);
        in_valid = iv;
        sel      = s;
        d        = dd;
        q_ready  = qr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_ready(input logic [1:0] s);
        return mq[s].size() < DEPTH;
    endfunction

    task automatic model_edge();
        logic rdy;
        rdy = model_ready(sel);
        for (int n = 0; n < 4; n++) begin
            if (q_ready[n] && mq[n].size() > 0) void'(mq[n].pop_front());
        end
        if (in_valid) begin
            if (rdy) mq[sel].push_back(d);
            else     m_ov = 1'b1;
        end
    endtask

    task automatic check_model(input int cyc);
        logic [7:0] eq [4];
        logic [3:0] eqv;
        for (int n = 0; n < 4; n++) begin
            eqv[n] = (mq[n].size() > 0);
            eq[n]  = eqv[n] ? mq[n][0] : 8'h00;
        end
        check_outs($sformatf("rand%0d", cyc), eq[0], eq[1], eq[2], eq[3], eqv, m_ov);
    endtask

    initial begin
        // Routing, then full-lane fill, overflow and drain on lane 1.
        vecs[0]  = '{1'b1, 2'd0, 8'h11, 4'h0, 1'b1, 8'h11, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 8'h22, 4'h0, 1'b1, 8'h11, 8'h22, 8'h00, 8'h00, 4'b0011, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 8'h33, 4'h0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h00, 4'b0111, 1'b0};
        vecs[3]  = '{1'b1, 2'd3, 8'h44, 4'h0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 1'b0};
        vecs[4]  = '{1'b0, 2'd3, 8'h00, 4'hF, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 2'd0, 8'hA0, 4'h0, 1'b1, 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 8'hA1, 4'h0, 1'b1, 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0};
        vecs[7]  = '{1'b1, 2'd0, 8'hA2, 4'h0, 1'b1, 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0};
        vecs[8]  = '{1'b1, 2'd0, 8'hA3, 4'h0, 1'b1, 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 8'hA4, 4'h0, 1'b0, 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 4'h1, 1'b0, 8'hA1, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 4'h1, 1'b1, 8'hA2, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 4'h1, 1'b1, 8'hA3, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 8'h00, 4'h1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        sel = 2'd0;
        d = '0;
        q_ready = 4'h0;
        #3;
        check_outs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].qr);
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4,
                       vecs[i].eqv, vecs[i].eov);
        end

        // Full lane 2: simultaneous push and pop, the push is refused.
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 2'd1, 8'hB0 + 8'(i), 4'h0);
            tick();
        end
        apply(1'b1, 2'd1, 8'hB4, 4'b0010);
        check("full2 in_ready", 32'(in_ready), 32'd0);
        check("full2 head", 32'(q2), 32'hB0);
        tick();
        check("full2 after q2", 32'(q2), 32'hB1);
        check("full2 after valid", 32'(q_valid[1]), 32'd1);
        apply(1'b0, 2'd1, 8'h00, 4'h0);
        check("full2 count3 in_ready", 32'(in_ready), 32'd1);
        apply(1'b0, 2'd1, 8'h00, 4'b0010);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("full2 drain%0d", k), 32'(q2), 32'hB0 + 32'(k));
            tick();
        end
        check("full2 empty", 32'(q_valid[1]), 32'd0);

        // Lane 3 wrap-around with occupancy held at 2.
        apply(1'b1, 2'd2, 8'hC0, 4'h0);
        tick();
        apply(1'b1, 2'd2, 8'hC1, 4'h0);
        tick();
        for (int k = 2; k < 10; k++) begin
            apply(1'b1, 2'd2, 8'hC0 + 8'(k), 4'b0100);
            check($sformatf("wrap head%0d", k - 2), 32'(q3), 32'hC0 + 32'(k - 2));
            check($sformatf("wrap ready%0d", k), 32'(in_ready), 32'd1);
            tick();
        end
        apply(1'b0, 2'd2, 8'h00, 4'b0100);
        for (int k = 8; k < 10; k++) begin
            check($sformatf("wrap head%0d", k), 32'(q3), 32'hC0 + 32'(k));
            tick();
        end
        check("wrap empty", 32'(q_valid), 32'd0);

        // Independent lanes: pop lanes 1 and 4 while pushing lane 2.
        apply(1'b1, 2'd0, 8'hD0, 4'h0); tick();
        apply(1'b1, 2'd0, 8'hD1, 4'h0); tick();
        apply(1'b1, 2'd3, 8'hE0, 4'h0); tick();
        apply(1'b1, 2'd2, 8'hF0, 4'h0); tick();
        apply(1'b1, 2'd1, 8'h90, 4'b1001);
        tick();
        check_outs("indep", 8'hD1, 8'h90, 8'hF0, 8'h00, 4'b0111, 1'b1);
        apply(1'b0, 2'd0, 8'h00, 4'h0);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check_outs("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid in_ready", 32'(in_ready), 32'd1);

        // Randomized traffic against the lane model.
        for (int n = 0; n < 4; n++) mq[n].delete();
        m_ov = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
                  4'($urandom) & 4'($urandom));
            check($sformatf("rand%0d in_ready", cyc), 32'(in_ready), 32'(model_ready(sel)));
            model_edge();
            tick();
            check_model(cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
